digit_counter: RTL and testbench
================================

# digit_counter

Multi-digit up/down counter with prescaler, synchronous load and clear, producing one 4-bit value per digit for direct connection to the `value` inputs of per-digit hex_display decoders. It sits directly upstream of the seven-segment decoders in the counter/shift-register lab datapath and is the only sequential stage feeding them. It also emits a one-cycle rollover pulse for chaining or LED indication.

## Interface
- NUM_DIGITS, 4, number of 4-bit digits (1–8)
- PRESCALE, 1, enabled clock cycles per count step (1–65535; 1 = step every enabled cycle)
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of digits and prescaler
- load  input  1  synchronous parallel load
- load_value  input  4*NUM_DIGITS  load data, digit 0 in bits [3:0]
- count_enable  input  1  advance prescaler/counter while high
- up  input  1  1 = count up, 0 = count down; sampled with each step
- digits  output  4*NUM_DIGITS  current count, digit 0 in bits [3:0]; one nibble per hex_display
- rollover_flag  output  1  one-cycle pulse when the full count wraps

## Operation
- Reset (n_rst low, asynchronous): digits = 0, prescaler = 0, rollover_flag = 0; held until n_rst released.
- Priority per cycle: clear > load > count > hold.
- clear: digits ← 0, prescaler ← 0, rollover_flag ← 0.
- load: digits ← load_value (BCD clamp below), prescaler ← 0, rollover_flag ← 0.
- Count: with count_enable high, prescaler increments; on the cycle it equals PRESCALE-1, a step occurs and prescaler ← 0. count_enable low freezes prescaler and digits.
- Step up: digit 0 increments; each digit at DIGIT_MAX wraps to 0 and carries into the next (ripple carry, combinational within the cycle).
- Step down: digit 0 decrements; each digit at 0 wraps to DIGIT_MAX and borrows from the next.
- Full wrap: up from all-DIGIT_MAX → all 0, or down from all 0 → all-DIGIT_MAX; rollover_flag = 1 for exactly the cycle the wrapped value is on digits, otherwise 0.
- Direction change mid-prescale: does not reset prescaler; new direction applies at next step.
- No FSM beyond prescaler and digit registers; all outputs registered.

## Timing
- Step latency: digits updates on the clk edge that ends the PRESCALE-th enabled cycle.
- clear/load latency: one clock edge; visible next cycle.
- rollover_flag registered, coincident with the wrapped digits value.
- digits is valid every cycle; downstream decoders are purely combinational, so display latency equals counter latency.
- n_rst deassertion mid-operation: counting resumes from 0 with prescaler 0.

## Configuration
- COUNTER_BCD_EN defined: DIGIT_MAX = 9; digits count 0–9; any loaded nibble > 9 is stored as 9.
- Undefined: DIGIT_MAX = 15; full hex 0–F; load_value stored unmodified.

## Structure
- Package digit_counter_pkg: typedef digit_t (4-bit), constant DIGIT_MAX (selected by COUNTER_BCD_EN), prescaler width constant PRESCALE_W = 16.
- Sub-module counter_digit: one 4-bit digit register with up/down, carry/borrow in and out, load, clear; instantiated NUM_DIGITS times via generate, carry chained digit 0 → NUM_DIGITS-1.
- Top level holds prescaler, step generation and rollover_flag register.

## Test plan
- Reset: drive n_rst low mid-count at digits = 0x1234 → digits = 0x0000, rollover_flag = 0 immediately, without a clk edge.
- Prescale: PRESCALE = 3, count_enable = 1, up = 1 from 0 → digits = 0x0001 after 3 edges, 0x0002 after 6; drop enable for 5 cycles → value and prescaler hold.
- Up wrap: load 0xFFFE (hex build), count up, PRESCALE = 1 → 0xFFFF then 0x0000 with rollover_flag = 1 for one cycle only.
- Down wrap/BCD: COUNTER_BCD_EN defined, load 0x0001, count down → 0x0000 then 0x9999 with rollover_flag pulse; load 0x00AF → stored 0x0099.
- Priority: clear, load = 0x4321 and count_enable all high in one cycle → 0x0000; load and count_enable high → 0x4321, prescaler 0.
- Carry ripple: load 0x00FF, step up → 0x0100; load 0x0100, step down → 0x00FF (hex build).

Source files
------------

// File: rtl/digit_counter_pkg.sv
// -----------------------------------------------------------------------------
// digit_counter_pkg
// Shared types and constants for the multi-digit up/down counter.
//
// Build option:
//   COUNTER_BCD_EN  defined   -> decimal digits 0-9, loaded nibbles > 9 stored as 9
//                   undefined -> hex digits 0-F, loaded nibbles stored unmodified
// -----------------------------------------------------------------------------
package digit_counter_pkg;

    typedef logic [3:0] digit_t;

    localparam int unsigned PRESCALE_W = 16;

`ifdef COUNTER_BCD_EN
    localparam digit_t DIGIT_MAX = 4'd9;
`else
    localparam digit_t DIGIT_MAX = 4'd15;
`endif

    // Maps a raw load nibble onto the legal digit range of this build.
    function automatic digit_t clamp_digit(input digit_t d);
`ifdef COUNTER_BCD_EN
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/digit_counter_counter_digit.sv
// -----------------------------------------------------------------------------
// counter_digit
// One 4-bit digit register of the ripple counter chain. Counts up or down by
// one when step_in is high, wrapping at 0 / DIGIT_MAX and flagging carry
// (up) or borrow (down) to the next digit on the same cycle.
//
// Build option: COUNTER_BCD_EN selects decimal (0-9) versus hex (0-F) digits.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   clear      in   synchronous clear to 0 (highest priority)
//   load       in   synchronous load of load_value (clamped to DIGIT_MAX)
//   load_value in   4-bit load nibble
//   up         in   1 = count up, 0 = count down
//   step_in    in   advance this digit this cycle (carry/borrow from below)
//   value      out  registered digit value
//   step_out   out  this digit wraps on this step; advances the next digit
// -----------------------------------------------------------------------------
module counter_digit
    import digit_counter_pkg::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   clear,
    input  logic   load,
    input  digit_t load_value,
    input  logic   up,
    input  logic   step_in,
    output digit_t value,
    output logic   step_out
);

    digit_t value_q;
    digit_t value_d;
    logic   at_limit;

    // Limit is the value that wraps in the current direction.
    assign at_limit = up ? (value_q == DIGIT_MAX) : (value_q == 4'd0);
    assign step_out = step_in && at_limit;
    assign value    = value_q;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (load) begin
            value_d = clamp_digit(load_value);
        end else if (step_in) begin
            if (up) begin
                value_d = at_limit ? 4'd0 : value_q + 4'd1;
            end else begin
                value_d = at_limit ? DIGIT_MAX : value_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/digit_counter.sv
// -----------------------------------------------------------------------------
// digit_counter
// Multi-digit up/down counter with prescaler, synchronous clear and load.
// Each 4-bit digit feeds one hex_display decoder directly. rollover_flag
// pulses for the single cycle in which the fully wrapped count is on digits.
//
// Build option: COUNTER_BCD_EN selects decimal digits (0-9, loads clamped
// to 9); otherwise digits are full hex.
//
// Parameters:
//   NUM_DIGITS  number of 4-bit digits (1-8)
//   PRESCALE    enabled cycles per count step (1-65535)
//
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous clear of digits and prescaler
//   load          in   synchronous parallel load
//   load_value    in   load data, digit 0 in bits [3:0]
//   count_enable  in   advance prescaler/counter while high
//   up            in   1 = up, 0 = down; sampled on each step
//   digits        out  current count, digit 0 in bits [3:0]
//   rollover_flag out  one-cycle pulse on full wrap
// -----------------------------------------------------------------------------
module digit_counter
    import digit_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    count_enable,
    input  logic                    up,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    rollover_flag
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_TC = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_d;
    logic                  rollover_q;
    logic                  rollover_d;
    logic                  step;
    logic [NUM_DIGITS:0]   carry;

    // clear and load take precedence, so a step only happens when neither is high.
    assign step     = count_enable && !clear && !load && (prescale_q == PRESCALE_TC);
    assign carry[0] = step;

    always_comb begin
        prescale_d = prescale_q;
        if (clear || load) begin
            prescale_d = '0;
        end else if (count_enable) begin
            prescale_d = step ? '0 : prescale_q + 1'b1;
        end
    end

    // A carry out of the top digit means every digit wrapped on this step.
    always_comb begin
        rollover_d = carry[NUM_DIGITS];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prescale_q <= '0;
            rollover_q <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            rollover_q <= rollover_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            counter_digit u_digit (
                .clk        (clk),
                .n_rst      (n_rst),
                .clear      (clear),
                .load       (load),
                .load_value (load_value[4*gi +: 4]),
                .up         (up),
                .step_in    (carry[gi]),
                .value      (digits[4*gi +: 4]),
                .step_out   (carry[gi+1])
            );
        end
    endgenerate

    assign rollover_flag = rollover_q;

endmodule

// File: tb/tb_digit_counter.sv
// Directed bench: one instance with PRESCALE=3 and one with PRESCALE=1 share
// all inputs. Inputs change on the falling edge; outputs are sampled there too.
module tb_digit_counter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        count_enable;
    logic        up;
    logic [15:0] digits_p3;
    logic [15:0] digits_p1;
    logic        rf_p3;
    logic        rf_p1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    digit_counter #(.NUM_DIGITS(4), .PRESCALE(3)) u_dut_p3 (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (load),
        .load_value    (load_value),
        .count_enable  (count_enable),
        .up            (up),
        .digits        (digits_p3),
        .rollover_flag (rf_p3)
    );

    digit_counter #(.NUM_DIGITS(4), .PRESCALE(1)) u_dut_p1 (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (load),
        .load_value    (load_value),
        .count_enable  (count_enable),
        .up            (up),
        .digits        (digits_p1),
        .rollover_flag (rf_p1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Loads v for one cycle, leaving count_enable low afterwards.
    task automatic do_load(input logic [15:0] v);
        load         = 1'b1;
        load_value   = v;
        count_enable = 1'b0;
        cycles(1);
        load = 1'b0;
    endtask

`ifdef COUNTER_BCD_EN
    localparam logic [15:0] ALL_MAX   = 16'h9999;
    localparam logic [15:0] UP_START  = 16'h9998;
    localparam logic [15:0] DN_AFTER  = 16'h9998;
    localparam logic [15:0] CLAMP_EXP = 16'h0099;
    localparam logic [15:0] RIP_LO    = 16'h0099;
`else
    localparam logic [15:0] ALL_MAX   = 16'hFFFF;
    localparam logic [15:0] UP_START  = 16'hFFFE;
    localparam logic [15:0] DN_AFTER  = 16'hFFFE;
    localparam logic [15:0] CLAMP_EXP = 16'h00AF;
    localparam logic [15:0] RIP_LO    = 16'h00FF;
`endif

    initial begin
        n_rst        = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        load_value   = 16'h0;
        count_enable = 1'b0;
        up           = 1'b1;
        #3;
        check("reset_digits_p3", digits_p3, 16'h0);
        check("reset_digits_p1", digits_p1, 16'h0);
        check("reset_rf",        rf_p1,     1'b0);
        cycles(2);
        n_rst = 1'b1;

        // Prescale: PRESCALE=3 steps every third enabled cycle.
        count_enable = 1'b1;
        cycles(3);
        check("pre_3edges", digits_p3, 16'h0001);
        check("p1_3edges",  digits_p1, 16'h0003);
        cycles(3);
        check("pre_6edges", digits_p3, 16'h0002);

        // Enable hold: one enabled cycle, five disabled, then two enabled.
        cycles(1);
        count_enable = 1'b0;
        cycles(5);
        check("hold_p3", digits_p3, 16'h0002);
        check("hold_p1", digits_p1, 16'h0007);
        count_enable = 1'b1;
        cycles(1);
        check("hold_resume_nostep", digits_p3, 16'h0002);
        cycles(1);
        check("hold_resume_step", digits_p3, 16'h0003);

        // Priority: clear beats load and count; load beats count and zeroes prescaler.
        clear = 1'b1; load = 1'b1; load_value = 16'h4321;
        cycles(1);
        check("prio_clear_p3", digits_p3, 16'h0000);
        check("prio_clear_p1", digits_p1, 16'h0000);
        clear = 1'b0;
        cycles(1);
        check("prio_load_p3", digits_p3, 16'h4321);
        check("prio_load_p1", digits_p1, 16'h4321);
        load = 1'b0;
        cycles(2);
        check("load_pre0_nostep", digits_p3, 16'h4321);
        cycles(1);
        check("load_pre0_step", digits_p3, 16'h4322);
        check("load_p1_count",  digits_p1, 16'h4324);

        // Up full wrap on PRESCALE=1.
        do_load(UP_START);
        up = 1'b1; count_enable = 1'b1;
        cycles(1);
        check("upwrap_max",    digits_p1, ALL_MAX);
        check("upwrap_max_rf", rf_p1,     1'b0);
        cycles(1);
        check("upwrap_zero",    digits_p1, 16'h0000);
        check("upwrap_zero_rf", rf_p1,     1'b1);
        cycles(1);
        check("upwrap_after",    digits_p1, 16'h0001);
        check("upwrap_after_rf", rf_p1,     1'b0);

        // Down full wrap on PRESCALE=1.
        do_load(16'h0001);
        up = 1'b0; count_enable = 1'b1;
        cycles(1);
        check("dnwrap_zero",    digits_p1, 16'h0000);
        check("dnwrap_zero_rf", rf_p1,     1'b0);
        cycles(1);
        check("dnwrap_max",    digits_p1, ALL_MAX);
        check("dnwrap_max_rf", rf_p1,     1'b1);
        cycles(1);
        check("dnwrap_after",    digits_p1, DN_AFTER);
        check("dnwrap_after_rf", rf_p1,     1'b0);

        // Load clamp (passes through in hex build).
        do_load(16'h00AF);
        check("load_clamp", digits_p1, CLAMP_EXP);

        // Carry / borrow ripple across digits.
        do_load(RIP_LO);
        up = 1'b1; count_enable = 1'b1;
        cycles(1);
        check("ripple_up", digits_p1, 16'h0100);
        check("ripple_up_rf", rf_p1, 1'b0);
        do_load(16'h0100);
        up = 1'b0; count_enable = 1'b1;
        cycles(1);
        check("ripple_dn", digits_p1, RIP_LO);

        // Direction change mid-prescale keeps the prescaler running.
        do_load(16'h0005);
        up = 1'b1; count_enable = 1'b1;
        cycles(2);
        up = 1'b0;
        cycles(1);
        check("dirchg_step", digits_p3, 16'h0004);

        // Asynchronous reset mid-count at 0x1234, checked before any clock edge.
        do_load(16'h1234);
        up = 1'b1; count_enable = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_p3", digits_p3, 16'h0000);
        check("async_rst_p1", digits_p1, 16'h0000);
        check("async_rst_rf", rf_p3,     1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cycles(2);
        check("rst_resume_nostep", digits_p3, 16'h0000);
        cycles(1);
        check("rst_resume_step", digits_p3, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
